// File: rtl/ap_fifo_frame_pkg.sv
// Shared constants, state encoding and checksum helpers for the framed
// ap_fifo checksum stage.
`timescale 1ns/1ps
package ap_fifo_frame_pkg;

   localparam int DATA_W = 128;
   localparam int LEN_W  = 32;

   typedef enum logic [1:0] {
      HDR     = 2'd0,
      PAYLOAD = 2'd1,
      TRAILER = 2'd2
   } state_e;

   // Trailer layout: {fold(xr), L[31:0], sum}
   localparam int TRL_XOR_LSB = 64;
   localparam int TRL_LEN_LSB = 32;
   localparam int TRL_SUM_LSB = 0;

   function automatic logic [31:0] lane_sum(input logic [DATA_W-1:0] d);
      return d[31:0] + d[63:32] + d[95:64] + d[127:96];
   endfunction

   function automatic logic [63:0] fold_xor(input logic [DATA_W-1:0] x);
      return x[127:64] ^ x[63:0];
   endfunction

endpackage

// File: rtl/ap_fifo_frame_checksum_acc.sv
// Running 32-bit lane sum and 128-bit xor over the payload words of one frame.
`timescale 1ns/1ps
module frame_csum_acc
   import ap_fifo_frame_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [31:0]       sum,
   output logic [DATA_W-1:0] xr
);

   // Clear wins over accumulate; both hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= 32'd0;
         xr  <= {DATA_W{1'b0}};
      end else if (clr) begin
         sum <= 32'd0;
         xr  <= {DATA_W{1'b0}};
      end else if (en) begin
         sum <= sum + lane_sum(din);
         xr  <= xr ^ din;
      end else begin
         sum <= sum;
         xr  <= xr;
      end
   end

endmodule

// File: rtl/ap_fifo_frame_checksum.sv
// Forwards framed 128-bit ap_fifo traffic unchanged and appends one checksum
// trailer word per frame; single output register with ready/full backpressure.
`timescale 1ns/1ps
module ap_fifo_frame_checksum #(
   parameter int DATA_W  = 128,
   parameter int LEN_W   = 32,
   parameter int MAX_LEN = 65536
) (
   input  logic              ip_clk,
   input  logic              ip_rst_n,
   input  logic [DATA_W-1:0] in_r_dout,
   input  logic              in_r_empty_n,
   output logic              in_r_read,
   output logic [DATA_W-1:0] out_r_din,
   output logic              out_r_write,
   input  logic              out_r_full,
   output logic [31:0]       frame_count,
   output logic              len_err,
   output logic              busy
);
   import ap_fifo_frame_pkg::*;

   generate
      if (DATA_W != 128) begin : g_bad_data_w
         $error("ap_fifo_frame_checksum: DATA_W must be 128");
      end
      if (LEN_W < 32 || LEN_W > DATA_W) begin : g_bad_len_w
         $error("ap_fifo_frame_checksum: LEN_W must be in 32..DATA_W");
      end
   endgenerate

   localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

   state_e              state_r;
   state_e              state_nx_s;
   logic [DATA_W-1:0]   obuf_r;
   logic                obuf_v_r;
   logic [LEN_W-1:0]    len_r;
   logic [LEN_W-1:0]    len_nx_s;
   logic [LEN_W-1:0]    rem_r;
   logic [LEN_W-1:0]    rem_nx_s;
   logic [31:0]         frame_count_r;
   logic                len_err_r;

   logic                slot_free_s;
   logic                acc_clr_s;
   logic                acc_en_s;
   logic                trl_load_s;
   logic                over_s;
   logic [LEN_W-1:0]    raw_len_s;
   logic [LEN_W-1:0]    clamp_len_s;
   logic [31:0]         sum_s;
   logic [DATA_W-1:0]   xr_s;
   logic [DATA_W-1:0]   trailer_s;

   frame_csum_acc u_acc (
      .clk   (ip_clk),
      .rst_n (ip_rst_n),
      .clr   (acc_clr_s),
      .en    (acc_en_s),
      .din   (in_r_dout),
      .sum   (sum_s),
      .xr    (xr_s)
   );

   // Handshake: a word may enter whenever the output slot drains this cycle.
   always_comb begin
      out_r_write = obuf_v_r & ~out_r_full;
      slot_free_s = ~obuf_v_r | out_r_write;
      in_r_read   = in_r_empty_n & slot_free_s & (state_r != TRAILER);
   end

   // Header length field, clamped to the largest legal payload count.
   always_comb begin
      raw_len_s = in_r_dout[LEN_W-1:0];
      over_s    = (raw_len_s > MAX_LEN_C);
      if (over_s) begin
         clamp_len_s = MAX_LEN_C;
      end else begin
         clamp_len_s = raw_len_s;
      end
   end

   // Trailer word assembled from the accumulators and the latched length.
   always_comb begin
      trailer_s                        = {DATA_W{1'b0}};
      trailer_s[TRL_XOR_LSB +: 64]     = fold_xor(xr_s);
      trailer_s[TRL_LEN_LSB +: 32]     = len_r[31:0];
      trailer_s[TRL_SUM_LSB +: 32]     = sum_s;
   end

   // Frame parser next-state logic.
   always_comb begin
      state_nx_s = state_r;
      len_nx_s   = len_r;
      rem_nx_s   = rem_r;
      acc_clr_s  = 1'b0;
      acc_en_s   = 1'b0;
      trl_load_s = 1'b0;
      case (state_r)
         HDR: begin
            if (in_r_read) begin
               len_nx_s  = clamp_len_s;
               rem_nx_s  = clamp_len_s;
               acc_clr_s = 1'b1;
               if (clamp_len_s != {LEN_W{1'b0}}) begin
                  state_nx_s = PAYLOAD;
               end else begin
                  state_nx_s = TRAILER;
               end
            end else begin
               state_nx_s = HDR;
            end
         end
         PAYLOAD: begin
            if (in_r_read) begin
               acc_en_s = 1'b1;
               rem_nx_s = rem_r - ONE_C;
               if (rem_r == ONE_C) begin
                  state_nx_s = TRAILER;
               end else begin
                  state_nx_s = PAYLOAD;
               end
            end else begin
               state_nx_s = PAYLOAD;
            end
         end
         TRAILER: begin
            if (slot_free_s) begin
               trl_load_s = 1'b1;
               state_nx_s = HDR;
            end else begin
               state_nx_s = TRAILER;
            end
         end
         default: begin
            state_nx_s = HDR;
         end
      endcase
   end

   // Parser state, frame length and remaining payload count.
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) begin
         state_r <= HDR;
         len_r   <= {LEN_W{1'b0}};
         rem_r   <= {LEN_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         len_r   <= len_nx_s;
         rem_r   <= rem_nx_s;
      end
   end

   // Output register: forwarded words and trailers never coincide.
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) begin
         obuf_r   <= {DATA_W{1'b0}};
         obuf_v_r <= 1'b0;
      end else if (in_r_read) begin
         obuf_r   <= in_r_dout;
         obuf_v_r <= 1'b1;
      end else if (trl_load_s) begin
         obuf_r   <= trailer_s;
         obuf_v_r <= 1'b1;
      end else if (out_r_write) begin
         obuf_r   <= obuf_r;
         obuf_v_r <= 1'b0;
      end else begin
         obuf_r   <= obuf_r;
         obuf_v_r <= obuf_v_r;
      end
   end

   // Status: trailer counter and sticky oversize-length flag.
   always_ff @(posedge ip_clk or negedge ip_rst_n) begin
      if (!ip_rst_n) begin
         frame_count_r <= 32'd0;
         len_err_r     <= 1'b0;
      end else begin
         if (trl_load_s) begin
            frame_count_r <= frame_count_r + 32'd1;
         end else begin
            frame_count_r <= frame_count_r;
         end
         if ((state_r == HDR) && in_r_read && over_s) begin
            len_err_r <= 1'b1;
         end else begin
            len_err_r <= len_err_r;
         end
      end
   end

   assign out_r_din   = obuf_r;
   assign frame_count = frame_count_r;
   assign len_err     = len_err_r;
   assign busy        = (state_r != HDR) | obuf_v_r;

endmodule

// File: tb/tb_ap_fifo_frame_checksum.sv
// Scoreboard bench: stimulus tasks queue source and expected words, a monitor
// pops and compares every output write.
`timescale 1ns/1ps
module tb_ap_fifo_frame_checksum;

   localparam int MAX_LEN = 65536;

   logic         ip_clk = 1'b0;
   logic         ip_rst_n = 1'b0;
   logic [127:0] in_r_dout = 128'h0;
   logic         in_r_empty_n = 1'b0;
   logic         in_r_read;
   logic [127:0] out_r_din;
   logic         out_r_write;
   logic         out_r_full = 1'b0;
   logic [31:0]  frame_count;
   logic         len_err;
   logic         busy;

   ap_fifo_frame_checksum dut (
      .ip_clk       (ip_clk),
      .ip_rst_n     (ip_rst_n),
      .in_r_dout    (in_r_dout),
      .in_r_empty_n (in_r_empty_n),
      .in_r_read    (in_r_read),
      .out_r_din    (out_r_din),
      .out_r_write  (out_r_write),
      .out_r_full   (out_r_full),
      .frame_count  (frame_count),
      .len_err      (len_err),
      .busy         (busy)
   );

   always #5 ip_clk = ~ip_clk;

   int           tests_run = 0;
   int           tests_failed = 0;
   logic [127:0] src_q[$];
   logic [127:0] exp_q[$];
   int           acc_cyc_q[$];
   int           acc_cnt = 0;
   int           wr_cnt = 0;
   int           cyc = 0;
   int           first_wr_cyc = 0;
   int           last_wr_cyc = 0;
   logic [127:0] last_word = 128'h0;
   int           valid_pct = 100;
   int           full_pct = 0;
   bit           toggle_full = 1'b0;
   bit           tog = 1'b0;
   logic [31:0]  m_len;
   logic [31:0]  m_sum;
   logic [127:0] m_xr;

   always @(posedge ip_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every DUT write is matched against the head of the scoreboard.
   always @(negedge ip_clk) begin
      #2;
      if (ip_rst_n && out_r_write) begin
         check("no_write_while_full", {127'h0, out_r_full}, 128'h0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", out_r_din, 128'hx);
         end else begin
            check("out_word", out_r_din, exp_q.pop_front());
         end
         wr_cnt++;
         if (wr_cnt == 1) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         last_word = out_r_din;
      end
   end

   task automatic step();
      @(negedge ip_clk);
      if (toggle_full) begin
         tog = ~tog;
         out_r_full = tog;
      end else begin
         out_r_full = ($urandom_range(99) < full_pct);
      end
      in_r_empty_n = (src_q.size() != 0) && ($urandom_range(99) < valid_pct);
      in_r_dout = (src_q.size() != 0) ? src_q[0] : 128'h0;
      #1;
      if (out_r_full && ((acc_cnt + int'(frame_count) - wr_cnt) != 0))
         check("read_while_held", {127'h0, in_r_read}, 128'h0);
      if (in_r_read) begin
         void'(src_q.pop_front());
         acc_cnt++;
         acc_cyc_q.push_back(cyc);
      end
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((src_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      tests_run++;
      if (n >= budget) begin
         tests_failed++;
         $display("FAIL %s_timeout: %0d cycles used, limit %0d", name, n, budget);
      end
   endtask

   task automatic do_reset();
      ip_rst_n = 1'b0;
      in_r_empty_n = 1'b0;
      out_r_full = 1'b0;
      toggle_full = 1'b0;
      tog = 1'b0;
      repeat (2) @(negedge ip_clk);
      src_q.delete();
      exp_q.delete();
      acc_cyc_q.delete();
      acc_cnt = 0;
      wr_cnt = 0;
      ip_rst_n = 1'b1;
   endtask

   task automatic push_hdr(input logic [127:0] h);
      src_q.push_back(h);
      exp_q.push_back(h);
      m_len = (h[31:0] > 32'(MAX_LEN)) ? 32'(MAX_LEN) : h[31:0];
      m_sum = 32'h0;
      m_xr = 128'h0;
   endtask

   task automatic push_pay(input logic [127:0] w);
      src_q.push_back(w);
      exp_q.push_back(w);
      m_sum = m_sum + w[31:0] + w[63:32] + w[95:64] + w[127:96];
      m_xr = m_xr ^ w;
   endtask

   task automatic push_trl_model();
      exp_q.push_back({m_xr[127:64] ^ m_xr[63:0], m_len, m_sum});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] len;
      // Reset values while held in reset
      #12;
      check("rst_out_r_write", {127'h0, out_r_write}, 128'h0);
      check("rst_in_r_read", {127'h0, in_r_read}, 128'h0);
      check("rst_out_r_din", out_r_din, 128'h0);
      check("rst_frame_count", {96'h0, frame_count}, 128'h0);
      check("rst_len_err", {127'h0, len_err}, 128'h0);
      check("rst_busy", {127'h0, busy}, 128'h0);

      // L=2 frame, no backpressure, hand-computed trailer
      do_reset();
      push_hdr({96'h0, 32'd2});
      push_pay({32'd4, 32'd3, 32'd2, 32'd1});
      push_pay({32'd8, 32'd7, 32'd6, 32'd5});
      exp_q.push_back({64'h0000_0008_0000_0000, 32'd2, 32'h24});
      drain(100, "t1");
      check("t1_frame_count", {96'h0, frame_count}, {96'h0, 32'd1});
      check("t1_writes", 128'(wr_cnt), 128'd4);
      check("t1_consecutive", 128'(last_wr_cyc - first_wr_cyc), 128'd3);

      // L=0 frames back to back, upper header bits forwarded verbatim
      do_reset();
      push_hdr({96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'd0});
      exp_q.push_back(128'h0);
      push_hdr({96'h0, 32'd0});
      exp_q.push_back(128'h0);
      drain(100, "t2");
      check("t2_frame_count", {96'h0, frame_count}, {96'h0, 32'd2});
      check("t2_hdr_gap", 128'(acc_cyc_q[1] - acc_cyc_q[0]), 128'd2);

      // Same frame as the first with out_r_full toggling
      do_reset();
      toggle_full = 1'b1;
      push_hdr({96'h0, 32'd2});
      push_pay({32'd4, 32'd3, 32'd2, 32'd1});
      push_pay({32'd8, 32'd7, 32'd6, 32'd5});
      exp_q.push_back({64'h0000_0008_0000_0000, 32'd2, 32'h24});
      drain(200, "t3");
      toggle_full = 1'b0;
      check("t3_frame_count", {96'h0, frame_count}, {96'h0, 32'd1});
      check("t3_writes", 128'(wr_cnt), 128'd4);

      // Oversized length is clamped and flagged
      do_reset();
      push_hdr({96'h0, 32'(MAX_LEN + 1)});
      for (int i = 0; i < MAX_LEN; i++)
         push_pay({32'(i), ~32'(i), 32'(i * 3), 32'hA5A5_0000 ^ 32'(i)});
      push_trl_model();
      n = 0;
      while (acc_cnt < 1 && n < 20) begin
         step();
         n++;
      end
      step();
      check("t4_len_err_set", {127'h0, len_err}, {127'h0, 1'b1});
      drain(80000, "t4");
      check("t4_len_err_sticky", {127'h0, len_err}, {127'h0, 1'b1});
      check("t4_trl_len", {96'h0, last_word[63:32]}, 128'(MAX_LEN));
      check("t4_consumed", 128'(acc_cnt), 128'(MAX_LEN + 1));
      check("t4_frame_count", {96'h0, frame_count}, {96'h0, 32'd1});

      // Reset mid-frame after the second payload word
      do_reset();
      push_hdr({96'h0, 32'd3});
      push_pay({32'h11, 32'h22, 32'h33, 32'h44});
      src_q.push_back({32'h55, 32'h66, 32'h77, 32'h88});
      n = 0;
      while (acc_cnt < 3 && n < 50) begin
         step();
         n++;
      end
      @(posedge ip_clk);
      #1;
      ip_rst_n = 1'b0;
      in_r_empty_n = 1'b0;
      #1;
      check("t5_out_r_write", {127'h0, out_r_write}, 128'h0);
      check("t5_in_r_read", {127'h0, in_r_read}, 128'h0);
      check("t5_out_r_din", out_r_din, 128'h0);
      check("t5_frame_count", {96'h0, frame_count}, 128'h0);
      check("t5_busy", {127'h0, busy}, 128'h0);
      check("t5_pre_reset_writes", 128'(wr_cnt), 128'd2);
      do_reset();
      push_hdr({96'h0, 32'd1});
      push_pay({32'h1, 32'h2, 32'h3, 32'h4});
      push_trl_model();
      drain(100, "t5b");
      check("t5b_frame_count", {96'h0, frame_count}, {96'h0, 32'd1});
      check("t5b_writes", 128'(wr_cnt), 128'd3);

      // Random frames with random stalls on both sides
      do_reset();
      valid_pct = 85;
      full_pct = 15;
      for (int f = 0; f < 1000; f++) begin
         len = 32'($urandom_range(16));
         push_hdr({$urandom, $urandom, $urandom, len});
         for (int p = 0; p < int'(len); p++)
            push_pay({$urandom, $urandom, $urandom, $urandom});
         push_trl_model();
      end
      drain(60000, "t6");
      check("t6_frame_count", {96'h0, frame_count}, {96'h0, 32'd1000});
      check("t6_len_err", {127'h0, len_err}, 128'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
